gen_senales_bus: RTL and testbench
==================================

# gen_senales_bus

Parametrised bus-cycle generator for the RTC's multiplexed address/data parallel port. It is the successor of the single-shot read/write control-signal generator in Ruta_Control. On a start request it produces the CS/RD/WR/A_D strobe sequence for one register or a burst of consecutive registers. The phase lengths are set by parameters. It also provides an address index and a data-latch pulse for the data path, and a busy/done handshake back to the general control FSM.

## Interface
- T_SU, 1: setup cycles before each strobe (≥1)
- T_STB, 4: strobe low width in cycles (≥1)
- T_HLD, 1: hold cycles after each strobe (≥1)
- T_GAP, 2: CS-high cycles between register cycles and after the last one (≥1)
- CW, 4: phase-counter width; must satisfy 2^CW > max(T_SU, T_STB, T_HLD, T_GAP)
- AW, 4: burst-index width
- reloj  in  1  system clock; all logic is on the rising edge
- resetM  in  1  asynchronous, active-low reset
- start  in  1  transaction request; sampled only in IDLE
- mode  in  2  01 = read, 10 = write; 00 and 11 are ignored (start has no effect)
- base_addr  in  8  first RTC register address
- count  in  AW  burst length minus 1
- busy  out  1  high from the cycle after an accepted start through the final GAP cycle
- done  out  1  one-cycle pulse on the last GAP cycle of a transaction
- CS, RD, WR  out  1 each  active-low bus strobes
- A_D  out  1  0 = address phase, 1 = data phase
- drive_en  out  1  FPGA drives the AD bus (address phase; data phase of a write)
- sel_addr  out  8  current register address = base_addr + idx
- idx  out  AW  current burst index
- LE  out  1  read-data latch enable
- abort  in  1  synchronous abort request

## Operation
- States: IDLE, A_SU, A_STB, A_HLD, D_SU, D_STB, D_HLD, GAP.
- Each timed state runs for its parameter's number of cycles, counted by a down-counter loaded on state entry.
- **IDLE:** `start` together with a valid mode latches mode, base_addr and count, and clears idx. The next state is A_SU. `start` is ignored in any other state.
- **A_SU / A_STB / A_HLD:**
  - CS=0, A_D=0, drive_en=1 throughout.
  - WR=0 only in A_STB; this is the address latch strobe for both read and write.
- **D_SU / D_STB / D_HLD:**
  - CS=0, A_D=1.
  - drive_en = 1 for write, 0 for read.
  - In D_STB, RD=0 (read) or WR=0 (write).
  - For a read, LE=1 on the final cycle of D_STB only.
- **D_HLD → GAP:** CS=1, RD=1, WR=1, A_D=1, drive_en=0.
- **GAP exit:**
  - If idx == latched count: done pulses on the last GAP cycle, then IDLE.
  - Otherwise: idx increments on the last GAP cycle, then A_SU.
- **Address arithmetic:** sel_addr is an 8-bit sum that wraps modulo 256 (base 0xFF, idx 1 gives 0x00). idx never exceeds count.
- **Abort:** `abort` sampled high in any non-IDLE, non-GAP state:
  - The next cycle enters GAP with all strobes released.
  - The transaction ends after T_GAP cycles with done pulsing.
  - Abort in GAP ends the burst at that GAP, with no further registers.
  - Abort in IDLE is ignored.
- **Simultaneous start + abort in IDLE:** start wins.

## Timing
- **Reset values:** CS=RD=WR=1, A_D=1, drive_en=0, LE=0, busy=0, done=0, idx=0, sel_addr=0, state IDLE.
- Asynchronous reset mid-strobe releases all strobes immediately and discards the transaction, with no done pulse.
- All outputs are registered (glitch-free strobes). Latency from the start edge to CS=0 is 1 cycle.
- One register cycle takes 2·(T_SU+T_STB+T_HLD)+T_GAP cycles; this is 14 with defaults.
- A burst of count+1 registers takes (count+1) times that.
- busy falls the cycle after done. A new start is accepted on that same cycle, allowing back-to-back transactions.
- A_D, drive_en and the address never change while RD or WR is low.

## Structure
- Shared package/header (Ruta_Control):
  - state encodings
  - mode constants (MODO_LEER=2'b01, MODO_ESCR=2'b10)
  - default phase parameters
- One sub-module, gen_fase_cnt: a CW-bit loadable down-counter with a terminal-count flag, instantiated once for phase timing.
- Burst index and FSM stay in the top.

## Test plan
- **Single read:** mode=01, base=0x21, count=0, defaults → CS low for exactly 12 cycles; WR low 4 cycles with A_D=0; RD low 4 cycles with A_D=1; LE high one cycle at the last RD-low cycle; done on cycle 14; drive_en=0 during the data phase.
- **Burst write:** mode=10, base=0xFE, count=2 → sel_addr 0xFE, 0xFF, 0x00; three CS windows separated by 2-cycle CS-high gaps; total busy = 42 cycles; exactly one done pulse.
- **Invalid/blocked start:** mode=00 or 11 with start → no strobe activity, busy stays 0. A start issued while busy is ignored, and the burst length is unchanged.
- **Abort mid-strobe:** abort during D_STB of register 1 of a count=3 read → strobes high next cycle; 2 GAP cycles; done pulse; idx stays 1; LE is never asserted for register 1.
- **Async reset mid-burst:** resetM low during A_STB → CS/WR high in the same cycle, no done pulse. After release, a new start runs a normal transaction.
- **Parameter sweep:** T_SU=2, T_STB=1, T_HLD=3, T_GAP=1 → the strobe is exactly 1 cycle and the register cycle is 2·6+1=13 cycles.

Source files
------------

// File: rtl/gen_senales_bus_pkg.sv
// Shared definitions for the RTC parallel-port bus-cycle generator: state encoding,
// mode constants and default phase lengths.
package gen_senales_bus_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A_SU  = 3'd1,
      A_STB = 3'd2,
      A_HLD = 3'd3,
      D_SU  = 3'd4,
      D_STB = 3'd5,
      D_HLD = 3'd6,
      GAP   = 3'd7
   } estado_t;

   localparam logic [1:0] MODO_LEER = 2'b01;
   localparam logic [1:0] MODO_ESCR = 2'b10;

   localparam int DEF_T_SU  = 1;
   localparam int DEF_T_STB = 4;
   localparam int DEF_T_HLD = 1;
   localparam int DEF_T_GAP = 2;
   localparam int DEF_CW    = 4;
   localparam int DEF_AW    = 4;

   function automatic logic modo_valido(input logic [1:0] m);
      return (m == MODO_LEER) || (m == MODO_ESCR);
   endfunction

   // Fixed phase order inside one register cycle.
   function automatic estado_t sig_fase(input estado_t s);
      case (s)
         A_SU:    return A_STB;
         A_STB:   return A_HLD;
         A_HLD:   return D_SU;
         D_SU:    return D_STB;
         D_STB:   return D_HLD;
         D_HLD:   return GAP;
         default: return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/gen_senales_bus_if.sv
// Request/handshake and bus-strobe bundle between the control FSM (master) and the
// bus-cycle generator (slave).
interface gen_senales_bus_if #(parameter int AW = 4);
   logic          start;
   logic [1:0]    mode;
   logic [7:0]    base_addr;
   logic [AW-1:0] count;
   logic          abort;
   logic          busy;
   logic          done;
   logic          CS;
   logic          RD;
   logic          WR;
   logic          A_D;
   logic          drive_en;
   logic [7:0]    sel_addr;
   logic [AW-1:0] idx;
   logic          LE;

   modport master (
      output start, mode, base_addr, count, abort,
      input  busy, done, CS, RD, WR, A_D, drive_en, sel_addr, idx, LE
   );

   modport slave (
      input  start, mode, base_addr, count, abort,
      output busy, done, CS, RD, WR, A_D, drive_en, sel_addr, idx, LE
   );
endinterface

// File: rtl/gen_fase_cnt.sv
// Loadable down-counter timing each bus phase; tc flags the last cycle of a phase and
// tc_nx tells whether the coming cycle will be a last cycle.
module gen_fase_cnt #(
   parameter int CW = 4
) (
   input  logic          reloj,
   input  logic          resetM,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tc,
   output logic          tc_nx
);
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nx_s;

   // Next count: reload on phase entry, otherwise count down and hold at zero.
   always_comb begin
      cnt_nx_s = cnt_r;
      if (load) begin
         cnt_nx_s = load_val;
      end else if (cnt_r != {CW{1'b0}}) begin
         cnt_nx_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_nx_s = cnt_r;
      end
   end

   // Counter register.
   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end

   assign tc    = (cnt_r == {CW{1'b0}});
   assign tc_nx = (cnt_nx_s == {CW{1'b0}});
endmodule

// File: rtl/gen_senales_bus.sv
// Bus-cycle generator for the RTC multiplexed address/data port: CS/RD/WR/A_D strobe
// sequences for single or burst register accesses, with busy/done handshake and abort.
module gen_senales_bus
   import gen_senales_bus_pkg::*;
#(
   parameter int T_SU  = DEF_T_SU,
   parameter int T_STB = DEF_T_STB,
   parameter int T_HLD = DEF_T_HLD,
   parameter int T_GAP = DEF_T_GAP,
   parameter int CW    = DEF_CW,
   parameter int AW    = DEF_AW
) (
   input logic              reloj,
   input logic              resetM,
   gen_senales_bus_if.slave bus
);
   estado_t       state_r, state_nx_s;
   logic [1:0]    mode_r, mode_nx_s;
   logic [7:0]    base_r, base_nx_s;
   logic [AW-1:0] count_r, count_nx_s;
   logic [AW-1:0] idx_r, idx_nx_s;
   logic          abort_r, abort_nx_s;
   logic          accept_s, last_reg_s, tc_s, tc_nx_s, load_s;
   logic [CW-1:0] load_val_s;

   logic          cs_r, rd_r, wr_r, a_d_r, drive_en_r, le_r, busy_r, done_r;
   logic [7:0]    sel_addr_r;
   logic          cs_nx_s, rd_nx_s, wr_nx_s, a_d_nx_s, drive_en_nx_s, le_nx_s;
   logic          busy_nx_s, done_nx_s;
   logic [7:0]    sel_addr_nx_s;
   logic          leer_s, escr_s;

   assign accept_s   = (state_r == IDLE) && bus.start && modo_valido(bus.mode);
   assign last_reg_s = (idx_r == count_r) || abort_r;

   gen_fase_cnt #(.CW(CW)) u_fase_cnt (
      .reloj    (reloj),
      .resetM   (resetM),
      .load     (load_s),
      .load_val (load_val_s),
      .tc       (tc_s),
      .tc_nx    (tc_nx_s)
   );

   // State register.
   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; an abort in GAP's last cycle re-runs GAP so done can still pulse.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nx_s = A_SU;
            else          state_nx_s = IDLE;
         end
         GAP: begin
            if (!tc_s)           state_nx_s = GAP;
            else if (last_reg_s) state_nx_s = IDLE;
            else if (bus.abort)  state_nx_s = GAP;
            else                 state_nx_s = A_SU;
         end
         default: begin
            if (bus.abort) state_nx_s = GAP;
            else if (tc_s) state_nx_s = sig_fase(state_r);
            else           state_nx_s = state_r;
         end
      endcase
   end

   // Transaction context, burst index and phase-counter reload.
   always_comb begin
      mode_nx_s  = mode_r;
      base_nx_s  = base_r;
      count_nx_s = count_r;
      idx_nx_s   = idx_r;
      if (accept_s) begin
         mode_nx_s  = bus.mode;
         base_nx_s  = bus.base_addr;
         count_nx_s = bus.count;
         idx_nx_s   = {AW{1'b0}};
      end else if ((state_r == GAP) && (state_nx_s == A_SU)) begin
         idx_nx_s = idx_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         idx_nx_s = idx_r;
      end
      abort_nx_s = (state_r != IDLE) && (state_nx_s != IDLE) && (abort_r || bus.abort);
      load_s     = tc_s || (state_nx_s != state_r);
      case (state_nx_s)
         A_SU, D_SU:   load_val_s = CW'(T_SU - 1);
         A_STB, D_STB: load_val_s = CW'(T_STB - 1);
         A_HLD, D_HLD: load_val_s = CW'(T_HLD - 1);
         GAP:          load_val_s = CW'(T_GAP - 1);
         default:      load_val_s = {CW{1'b0}};
      endcase
   end

   // Context registers.
   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         mode_r  <= 2'b00;
         base_r  <= 8'h00;
         count_r <= {AW{1'b0}};
         idx_r   <= {AW{1'b0}};
         abort_r <= 1'b0;
      end else begin
         mode_r  <= mode_nx_s;
         base_r  <= base_nx_s;
         count_r <= count_nx_s;
         idx_r   <= idx_nx_s;
         abort_r <= abort_nx_s;
      end
   end

   assign leer_s = (mode_nx_s == MODO_LEER);
   assign escr_s = (mode_nx_s == MODO_ESCR);

   // Output decode from the next state, so the registered strobes line up with state_r.
   always_comb begin
      cs_nx_s       = 1'b1;
      rd_nx_s       = 1'b1;
      wr_nx_s       = 1'b1;
      a_d_nx_s      = 1'b1;
      drive_en_nx_s = 1'b0;
      le_nx_s       = 1'b0;
      case (state_nx_s)
         A_SU, A_HLD: begin
            cs_nx_s       = 1'b0;
            a_d_nx_s      = 1'b0;
            drive_en_nx_s = 1'b1;
         end
         A_STB: begin
            cs_nx_s       = 1'b0;
            a_d_nx_s      = 1'b0;
            drive_en_nx_s = 1'b1;
            wr_nx_s       = 1'b0;
         end
         D_SU, D_HLD: begin
            cs_nx_s       = 1'b0;
            drive_en_nx_s = escr_s;
         end
         D_STB: begin
            cs_nx_s       = 1'b0;
            drive_en_nx_s = escr_s;
            rd_nx_s       = !leer_s;
            wr_nx_s       = !escr_s;
            le_nx_s       = leer_s && tc_nx_s;
         end
         default: begin
            cs_nx_s = 1'b1;
         end
      endcase
      busy_nx_s     = (state_nx_s != IDLE);
      done_nx_s     = (state_nx_s == GAP) && tc_nx_s && ((idx_nx_s == count_nx_s) || abort_nx_s);
      sel_addr_nx_s = base_nx_s + 8'(idx_nx_s);
   end

   // Output registers keep the strobes glitch-free.
   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         cs_r       <= 1'b1;
         rd_r       <= 1'b1;
         wr_r       <= 1'b1;
         a_d_r      <= 1'b1;
         drive_en_r <= 1'b0;
         le_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         sel_addr_r <= 8'h00;
      end else begin
         cs_r       <= cs_nx_s;
         rd_r       <= rd_nx_s;
         wr_r       <= wr_nx_s;
         a_d_r      <= a_d_nx_s;
         drive_en_r <= drive_en_nx_s;
         le_r       <= le_nx_s;
         busy_r     <= busy_nx_s;
         done_r     <= done_nx_s;
         sel_addr_r <= sel_addr_nx_s;
      end
   end

   assign bus.CS       = cs_r;
   assign bus.RD       = rd_r;
   assign bus.WR       = wr_r;
   assign bus.A_D      = a_d_r;
   assign bus.drive_en = drive_en_r;
   assign bus.LE       = le_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.sel_addr = sel_addr_r;
   assign bus.idx      = idx_r;
endmodule

// File: tb/tb_gen_senales_bus.sv
// Bench for gen_senales_bus: default and swept-timing instances driven in parallel and
// checked every cycle against a timeline model, plus hand-computed directed checks.
module tb_gen_senales_bus;
   import gen_senales_bus_pkg::*;

   logic       reloj  = 1'b0;
   logic       resetM = 1'b1;
   logic       start  = 1'b0;
   logic       abort  = 1'b0;
   logic [1:0] mode   = 2'b00;
   logic [7:0] base   = 8'h00;
   logic [3:0] count  = 4'h0;
   logic       chk_en = 1'b0;
   int         tests  = 0;
   int         fails  = 0;

   always #5 reloj = ~reloj;

   gen_senales_bus_if #(.AW(4)) bus0 ();
   gen_senales_bus_if #(.AW(4)) bus1 ();

   assign bus0.start = start;  assign bus1.start = start;
   assign bus0.abort = abort;  assign bus1.abort = abort;
   assign bus0.mode  = mode;   assign bus1.mode  = mode;
   assign bus0.base_addr = base;  assign bus1.base_addr = base;
   assign bus0.count = count;  assign bus1.count = count;

   gen_senales_bus #(.T_SU(1), .T_STB(4), .T_HLD(1), .T_GAP(2), .CW(4), .AW(4)) dut0 (
      .reloj(reloj), .resetM(resetM), .bus(bus0));
   gen_senales_bus #(.T_SU(2), .T_STB(1), .T_HLD(3), .T_GAP(1), .CW(4), .AW(4)) dut1 (
      .reloj(reloj), .resetM(resetM), .bus(bus1));

   // Model: each transaction is a timeline of register cycles, position t inside one.
   int su[2]  = '{1, 2};
   int stb[2] = '{4, 1};
   int hld[2] = '{1, 3};
   int gp[2]  = '{2, 1};
   bit m_act[2] = '{0, 0};
   bit m_ab[2]  = '{0, 0};
   int m_t[2]   = '{0, 0};
   int m_reg[2] = '{0, 0};
   int m_cnt[2] = '{0, 0};
   int m_base[2] = '{0, 0};
   logic [1:0] m_mode[2] = '{2'b00, 2'b00};

   task automatic model_step(input int d);
      int p, l;
      p = su[d] + stb[d] + hld[d];
      l = 2 * p + gp[d];
      if (!m_act[d]) begin
         if (start && (mode == 2'b01 || mode == 2'b10)) begin
            m_act[d] = 1'b1; m_t[d] = 0; m_reg[d] = 0; m_ab[d] = 1'b0;
            m_mode[d] = mode; m_base[d] = int'(base); m_cnt[d] = int'(count);
         end
      end else if (abort && m_t[d] < 2 * p) begin
         m_t[d] = 2 * p; m_ab[d] = 1'b1;
      end else if (m_t[d] == l - 1) begin
         if (m_reg[d] == m_cnt[d] || m_ab[d]) m_act[d] = 1'b0;
         else if (abort) begin m_t[d] = 2 * p; m_ab[d] = 1'b1; end
         else begin m_reg[d]++; m_t[d] = 0; end
      end else begin
         if (abort) m_ab[d] = 1'b1;
         m_t[d]++;
      end
   endtask

   always @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_ab[d] = 1'b0; m_t[d] = 0; m_reg[d] = 0; m_base[d] = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) model_step(d);
      end
   end

   // {busy, done, CS, RD, WR, A_D, drive_en, LE, idx[3:0], sel_addr[7:0]}
   function automatic logic [19:0] model_out(input int d);
      logic bsy, dn, cs, rd, wr, ad, drv, le, rdm, strobe;
      int p, u;
      bsy = 1'b0; dn = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b1; drv = 1'b0; le = 1'b0;
      p = su[d] + stb[d] + hld[d];
      if (m_act[d]) begin
         bsy = 1'b1;
         rdm = (m_mode[d] == 2'b01);
         if (m_t[d] < p) begin
            cs = 1'b0; ad = 1'b0; drv = 1'b1;
            wr = !(m_t[d] >= su[d] && m_t[d] < su[d] + stb[d]);
         end else if (m_t[d] < 2 * p) begin
            u = m_t[d] - p;
            strobe = (u >= su[d] && u < su[d] + stb[d]);
            cs = 1'b0; drv = !rdm;
            if (rdm) rd = !strobe;
            else     wr = !strobe;
            le = rdm && (u == su[d] + stb[d] - 1);
         end else begin
            dn = (m_t[d] == 2 * p + gp[d] - 1) && (m_reg[d] == m_cnt[d] || m_ab[d]);
         end
      end
      return {bsy, dn, cs, rd, wr, ad, drv, le, 4'(m_reg[d]), 8'(m_base[d] + m_reg[d])};
   endfunction

   int busy_n[2], done_n[2], done_at[2], cs_low[2], gap_n[2], cs_win[2], rd_low[2];
   int rd_ad1[2], wr_low[2], wr_ad0[2], drv_data[2], le_n[2], rd_at_le[2];
   bit cs_prev[2] = '{1, 1};
   logic [7:0] sel_q[$];

   task automatic stat(input int d, input logic bsy, dn, cs, rd, wr, ad, drv, le,
                       input logic [7:0] sel);
      if (bsy) busy_n[d]++;
      if (dn) begin done_n[d]++; done_at[d] = busy_n[d]; end
      if (!cs) cs_low[d]++;
      if (bsy && cs) gap_n[d]++;
      if (!cs && cs_prev[d]) begin cs_win[d]++; if (d == 0) sel_q.push_back(sel); end
      cs_prev[d] = cs;
      if (!rd) rd_low[d]++;
      if (!rd && ad) rd_ad1[d]++;
      if (!wr) wr_low[d]++;
      if (!wr && !ad) wr_ad0[d]++;
      if (!cs && ad && drv) drv_data[d]++;
      if (le) begin le_n[d]++; rd_at_le[d] = rd ? -1 : rd_low[d]; end
   endtask

   task automatic clr_stats();
      for (int d = 0; d < 2; d++) begin
         busy_n[d] = 0; done_n[d] = 0; done_at[d] = 0; cs_low[d] = 0; gap_n[d] = 0;
         cs_win[d] = 0; rd_low[d] = 0; rd_ad1[d] = 0; wr_low[d] = 0; wr_ad0[d] = 0;
         drv_data[d] = 0; le_n[d] = 0; rd_at_le[d] = 0;
      end
      sel_q.delete();
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge reloj) begin
      logic [19:0] act, exp_v;
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            if (d == 0) act = {bus0.busy, bus0.done, bus0.CS, bus0.RD, bus0.WR, bus0.A_D,
                               bus0.drive_en, bus0.LE, bus0.idx, bus0.sel_addr};
            else        act = {bus1.busy, bus1.done, bus1.CS, bus1.RD, bus1.WR, bus1.A_D,
                               bus1.drive_en, bus1.LE, bus1.idx, bus1.sel_addr};
            exp_v = model_out(d);
            tests++;
            if (act !== exp_v) begin
               fails++;
               $display("FAIL cycle dut%0d @%0t: got %h, required %h", d, $time, act, exp_v);
            end
         end
         stat(0, bus0.busy, bus0.done, bus0.CS, bus0.RD, bus0.WR, bus0.A_D, bus0.drive_en,
              bus0.LE, bus0.sel_addr);
         stat(1, bus1.busy, bus1.done, bus1.CS, bus1.RD, bus1.WR, bus1.A_D, bus1.drive_en,
              bus1.LE, bus1.sel_addr);
      end
   end

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic begin_test();
      @(negedge reloj);
      #1 clr_stats();
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [7:0] b, input logic [3:0] c);
      @(negedge reloj);
      start = 1'b1; mode = m; base = b; count = c;
      @(negedge reloj);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string what);
      int n;
      n = 0;
      while ((bus0.busy || bus1.busy) && n < 3000) begin
         @(negedge reloj);
         n++;
      end
      tests++;
      if (bus0.busy || bus1.busy) begin
         fails++;
         $display("FAIL %s timeout: still busy after %0d cycles, required idle", what, n);
      end
      #1;
   endtask

   int exp_sel[3] = '{254, 255, 0};
   int n;

   initial begin
      #2 resetM = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge reloj);
      resetM = 1'b1;
      @(negedge reloj); #1;
      chk("reset CS", int'(bus0.CS), 1);
      chk("reset RD", int'(bus0.RD), 1);
      chk("reset WR", int'(bus0.WR), 1);
      chk("reset A_D", int'(bus0.A_D), 1);
      chk("reset drive_en", int'(bus0.drive_en), 0);
      chk("reset LE", int'(bus0.LE), 0);
      chk("reset busy", int'(bus0.busy), 0);
      chk("reset done", int'(bus0.done), 0);
      chk("reset idx", int'(bus0.idx), 0);
      chk("reset sel_addr", int'(bus0.sel_addr), 0);

      // Single read, count 0.
      begin_test();
      pulse_start(2'b01, 8'h21, 4'd0);
      wait_idle("single read");
      chk("read cs_low", cs_low[0], 12);
      chk("read wr_low_ad0", wr_ad0[0], 4);
      chk("read rd_low_ad1", rd_ad1[0], 4);
      chk("read le count", le_n[0], 1);
      chk("read le at last rd", rd_at_le[0], 4);
      chk("read done count", done_n[0], 1);
      chk("read done cycle", done_at[0], 14);
      chk("read busy", busy_n[0], 14);
      chk("read data drive", drv_data[0], 0);
      chk("read sel_addr", int'(bus0.sel_addr), 'h21);
      chk("sweep busy", busy_n[1], 13);
      chk("sweep rd_low", rd_low[1], 1);
      chk("sweep wr_low", wr_low[1], 1);
      chk("sweep cs_low", cs_low[1], 12);
      chk("sweep done cycle", done_at[1], 13);

      // Burst write, count 2, with an ignored start in the middle.
      begin_test();
      pulse_start(2'b10, 8'hFE, 4'd2);
      repeat (5) @(negedge reloj);
      pulse_start(2'b01, 8'h00, 4'd0);
      wait_idle("burst write");
      chk("burst busy", busy_n[0], 42);
      chk("burst done count", done_n[0], 1);
      chk("burst cs windows", cs_win[0], 3);
      chk("burst gap cycles", gap_n[0], 6);
      chk("burst cs_low", cs_low[0], 36);
      chk("burst wr_low", wr_low[0], 24);
      chk("burst rd_low", rd_low[0], 0);
      chk("burst data drive", drv_data[0], 18);
      chk("burst sel count", sel_q.size(), 3);
      for (int i = 0; i < sel_q.size() && i < 3; i++) chk("burst sel_addr", int'(sel_q[i]), exp_sel[i]);
      chk("sweep burst busy", busy_n[1], 39);

      // Invalid modes.
      begin_test();
      pulse_start(2'b00, 8'h55, 4'd1);
      repeat (3) @(negedge reloj);
      pulse_start(2'b11, 8'h66, 4'd1);
      repeat (10) @(negedge reloj);
      #1;
      chk("invalid busy dut0", busy_n[0], 0);
      chk("invalid cs_low dut0", cs_low[0], 0);
      chk("invalid busy dut1", busy_n[1], 0);

      // Abort during D_STB of register 1 of a 4-register read.
      begin_test();
      pulse_start(2'b01, 8'h40, 4'd3);
      n = 0;
      while (!(bus0.idx == 4'd1 && !bus0.RD) && n < 200) begin @(negedge reloj); n++; end
      chk("abort reached reg1 D_STB", int'(bus0.idx == 4'd1 && !bus0.RD), 1);
      abort = 1'b1;
      @(negedge reloj);
      abort = 1'b0;
      chk("abort CS released", int'(bus0.CS), 1);
      chk("abort RD released", int'(bus0.RD), 1);
      wait_idle("abort");
      chk("abort busy", busy_n[0], 24);
      chk("abort done count", done_n[0], 1);
      chk("abort le count", le_n[0], 1);
      chk("abort idx", int'(bus0.idx), 1);
      chk("abort sel_addr", int'(bus0.sel_addr), 'h41);

      // Asynchronous reset during A_STB.
      begin_test();
      pulse_start(2'b10, 8'h10, 4'd2);
      n = 0;
      while (!(!bus0.WR && !bus0.A_D) && n < 50) begin @(negedge reloj); n++; end
      chk("reset reached A_STB", int'(!bus0.WR && !bus0.A_D), 1);
      #2 resetM = 1'b0;
      #1;
      chk("async reset CS", int'(bus0.CS), 1);
      chk("async reset WR", int'(bus0.WR), 1);
      chk("async reset busy", int'(bus0.busy), 0);
      @(negedge reloj);
      resetM = 1'b1;
      repeat (4) @(negedge reloj);
      #1;
      chk("async reset no done", done_n[0], 0);
      begin_test();
      pulse_start(2'b01, 8'h33, 4'd0);
      wait_idle("after reset");
      chk("after reset busy", busy_n[0], 14);
      chk("after reset done", done_n[0], 1);
      chk("after reset cs_low", cs_low[0], 12);
      chk("after reset sel_addr", int'(bus0.sel_addr), 'h33);

      // Randomised traffic, including back-to-back starts and aborts.
      for (int c = 0; c < 3000; c++) begin
         @(negedge reloj);
         start = ($urandom_range(0, 5) == 0);
         mode  = 2'($urandom_range(0, 3));
         base  = 8'($urandom_range(0, 255));
         count = 4'($urandom_range(0, 3));
         abort = ($urandom_range(0, 49) == 0);
      end
      @(negedge reloj);
      start = 1'b0;
      abort = 1'b0;
      wait_idle("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
